// File: rtl/mmu_xlat_pkg.sv
// Shared types and constants for the MMU translation request sequencer.
package mmu_xlat_pkg;

  localparam int unsigned XLAT_VLEN = 64;
  localparam int unsigned XLAT_PLEN = 56;
  localparam int unsigned XLEN      = 64;

  localparam logic [XLEN-1:0] LOAD_PAGE_FAULT  = 64'd13;
  localparam logic [XLEN-1:0] STORE_PAGE_FAULT = 64'd15;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    DRAIN,
    DISCARD
  } state_e;

  typedef struct packed {
    logic [XLAT_VLEN-1:0] vaddr;
    logic                 is_store;
  } xlat_req_t;

  typedef struct packed {
    logic [XLAT_PLEN-1:0] paddr;
    logic                 ex_valid;
    logic [XLEN-1:0]      cause;
    logic [XLEN-1:0]      tval;
    logic                 timeout;
  } xlat_rsp_t;

endpackage

// File: rtl/mmu_xlat_sequencer_fifo.sv
// Synchronous request FIFO with single-cycle flush; no read-through of a same-cycle push.
module mmu_xlat_fifo
  import mmu_xlat_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      flush_i,
  input  logic      push_i,
  input  xlat_req_t data_i,
  input  logic      pop_i,
  output xlat_req_t data_o,
  output logic      empty_o,
  output logic      full_o
);

  localparam int unsigned AW = $clog2(Depth);

  xlat_req_t   mem_q [Depth];
  xlat_req_t   mem_d [Depth];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i && !full_o) begin
        mem_d[wr_ptr_q[AW-1:0]] = data_i;
        wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (pop_i && !empty_o) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: pointers alone define validity.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mmu_xlat_sequencer.sv
// Buffers translation requests, issues them one at a time to the MMU and
// returns in-order responses, with bypass, timeout, flush and fault drain.
module mmu_xlat_sequencer
  import mmu_xlat_pkg::*;
#(
  parameter int unsigned VLEN          = XLAT_VLEN,
  parameter int unsigned PLEN          = XLAT_PLEN,
  parameter int unsigned ReqDepth      = 4,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_ld_st_translation_i,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [VLEN-1:0] req_vaddr_i,
  input  logic            req_is_store_i,
  output logic            mmu_req_o,
  output logic [VLEN-1:0] mmu_vaddr_o,
  output logic            mmu_is_store_o,
  input  logic            mmu_valid_i,
  input  logic [PLEN-1:0] mmu_paddr_i,
  input  logic            mmu_ex_valid_i,
  input  logic [63:0]     mmu_ex_cause_i,
  input  logic [63:0]     mmu_ex_tval_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [PLEN-1:0] rsp_paddr_o,
  output logic            rsp_ex_valid_o,
  output logic [63:0]     rsp_ex_cause_o,
  output logic [63:0]     rsp_ex_tval_o,
  output logic            rsp_timeout_o,
  output logic            busy_o
);

  localparam int unsigned    CW      = $clog2(TimeoutCycles + 1);
  localparam logic [CW-1:0]  CntLast = CW'(TimeoutCycles - 1);

  state_e        state_q, state_d;
  xlat_req_t     work_q, work_d;
  xlat_rsp_t     rsp_q, rsp_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_sat;

  xlat_req_t fifo_wdata, fifo_rdata;
  logic      fifo_push, fifo_pop, fifo_flush, fifo_empty, fifo_full;

  assign req_ready_o = !fifo_full && (state_q != DRAIN) && !flush_i;
  assign fifo_push   = req_valid_i && req_ready_o;
  assign fifo_flush  = flush_i || (state_q == DRAIN);
  assign fifo_wdata  = '{vaddr: XLAT_VLEN'(req_vaddr_i), is_store: req_is_store_i};
  assign cnt_sat     = (cnt_q == CntLast) ? cnt_q : cnt_q + 1'b1;

  mmu_xlat_fifo #(
    .Depth (ReqDepth)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    rsp_d    = rsp_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    // An outstanding MMU answer must be absorbed before a new request may issue.
    if (flush_i && (state_q != DISCARD)) begin
      cnt_d   = cnt_sat;
      state_d = (state_q == WAIT && !mmu_valid_i && cnt_q != CntLast) ? DISCARD : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            work_d   = fifo_rdata;
            if (en_ld_st_translation_i) begin
              state_d = ISSUE;
            end else begin
              rsp_d       = '0;
              rsp_d.paddr = fifo_rdata.vaddr[XLAT_PLEN-1:0];
              state_d     = RESP;
            end
          end
        end
        ISSUE: begin
          cnt_d   = '0;
          state_d = WAIT;
        end
        WAIT: begin
          cnt_d = cnt_sat;
          if (mmu_valid_i) begin
            rsp_d.paddr    = XLAT_PLEN'(mmu_paddr_i);
            rsp_d.ex_valid = mmu_ex_valid_i;
            rsp_d.cause    = mmu_ex_cause_i;
            rsp_d.tval     = mmu_ex_tval_i;
            rsp_d.timeout  = 1'b0;
            state_d        = RESP;
          end else if (cnt_q == CntLast) begin
            rsp_d         = '0;
            rsp_d.timeout = 1'b1;
            state_d       = RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_d = (rsp_q.ex_valid || rsp_q.timeout) ? DRAIN : IDLE;
          end
        end
        DRAIN: begin
          state_d = IDLE;
        end
        DISCARD: begin
          cnt_d = cnt_sat;
          if (mmu_valid_i || cnt_q == CntLast) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      work_q  <= '0;
      rsp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rsp_q   <= rsp_d;
      cnt_q   <= cnt_d;
    end
  end

  // A request flushed while in ISSUE is never shown to the MMU.
  assign mmu_req_o      = (state_q == ISSUE) && !flush_i;
  assign mmu_vaddr_o    = VLEN'(work_q.vaddr);
  assign mmu_is_store_o = work_q.is_store;

  assign rsp_valid_o    = (state_q == RESP);
  assign rsp_paddr_o    = PLEN'(rsp_q.paddr);
  assign rsp_ex_valid_o = rsp_q.ex_valid;
  assign rsp_ex_cause_o = rsp_q.cause;
  assign rsp_ex_tval_o  = rsp_q.tval;
  assign rsp_timeout_o  = rsp_q.timeout;
  assign busy_o         = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_mmu_xlat_sequencer.sv
// Directed bench for mmu_xlat_sequencer with a small latency-programmable MMU responder.
module tb_mmu_xlat_sequencer;
  import mmu_xlat_pkg::*;

  localparam int unsigned TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_ld_st_translation_i;
  logic        flush_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [63:0] req_vaddr_i;
  logic        req_is_store_i;
  logic        mmu_req_o;
  logic [63:0] mmu_vaddr_o;
  logic        mmu_is_store_o;
  logic        mmu_valid_i    = 1'b0;
  logic [55:0] mmu_paddr_i    = '0;
  logic        mmu_ex_valid_i = 1'b0;
  logic [63:0] mmu_ex_cause_i = '0;
  logic [63:0] mmu_ex_tval_i  = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [55:0] rsp_paddr_o;
  logic        rsp_ex_valid_o;
  logic [63:0] rsp_ex_cause_o;
  logic [63:0] rsp_ex_tval_o;
  logic        rsp_timeout_o;
  logic        busy_o;

  int n_chk  = 0;
  int n_pass = 0;

  // Responder configuration (written by the main sequence only).
  int          mmu_lat   = 3;
  logic [63:0] fault_va  = '1;
  logic [63:0] ovr_va    = '1;
  int          ovr_lat   = 0;
  logic [55:0] ovr_paddr = '0;
  int          n_mmu_req = 0;
  logic [63:0] r_va;
  logic        r_st;
  int          r_lat;

  mmu_xlat_sequencer #(
    .VLEN          (64),
    .PLEN          (56),
    .ReqDepth      (4),
    .TimeoutCycles (TO)
  ) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .en_ld_st_translation_i (en_ld_st_translation_i),
    .flush_i                (flush_i),
    .req_valid_i            (req_valid_i),
    .req_ready_o            (req_ready_o),
    .req_vaddr_i            (req_vaddr_i),
    .req_is_store_i         (req_is_store_i),
    .mmu_req_o              (mmu_req_o),
    .mmu_vaddr_o            (mmu_vaddr_o),
    .mmu_is_store_o         (mmu_is_store_o),
    .mmu_valid_i            (mmu_valid_i),
    .mmu_paddr_i            (mmu_paddr_i),
    .mmu_ex_valid_i         (mmu_ex_valid_i),
    .mmu_ex_cause_i         (mmu_ex_cause_i),
    .mmu_ex_tval_i          (mmu_ex_tval_i),
    .rsp_valid_o            (rsp_valid_o),
    .rsp_ready_i            (rsp_ready_i),
    .rsp_paddr_o            (rsp_paddr_o),
    .rsp_ex_valid_o         (rsp_ex_valid_o),
    .rsp_ex_cause_o         (rsp_ex_cause_o),
    .rsp_ex_tval_o          (rsp_ex_tval_o),
    .rsp_timeout_o          (rsp_timeout_o),
    .busy_o                 (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // MMU model: identity mapping, answer 'lat' cycles after the request pulse.
  always begin
    @(posedge clk_i);
    if (mmu_req_o) begin
      n_mmu_req++;
      r_va  = mmu_vaddr_o;
      r_st  = mmu_is_store_o;
      r_lat = (r_va == ovr_va) ? ovr_lat : mmu_lat;
      if (r_lat > 0) begin
        repeat (r_lat) @(negedge clk_i);
        mmu_valid_i    = 1'b1;
        mmu_paddr_i    = (r_va == ovr_va) ? ovr_paddr : r_va[55:0];
        mmu_ex_valid_i = (r_va == fault_va);
        mmu_ex_cause_i = (r_va == fault_va) ? (r_st ? STORE_PAGE_FAULT : LOAD_PAGE_FAULT) : 64'd0;
        mmu_ex_tval_i  = (r_va == fault_va) ? r_va : 64'd0;
        @(negedge clk_i);
        mmu_valid_i    = 1'b0;
        mmu_ex_valid_i = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  logic [63:0] va2 [6];
  logic [63:0] pa2 [6];
  int          cnt, acc, k, base, extra;
  logic [63:0] exp3_cause;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; en_ld_st_translation_i = 1'b1; flush_i = 1'b0;
    req_valid_i = 1'b0; req_vaddr_i = '0; req_is_store_i = 1'b0; rsp_ready_i = 1'b1;
    step(); step();
    rst_i = 1'b0;
    #1;
    check("rst_ready", 64'(req_ready_o), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_mmu_req", 64'(mmu_req_o), 64'd0);
    check("rst_paddr", 64'(rsp_paddr_o), 64'd0);

    // 1: translated load, MMU latency 3
    base = n_mmu_req;
    req_valid_i = 1'b1; req_vaddr_i = 64'h8000_1000; req_is_store_i = 1'b0;
    check("t1_ready", 64'(req_ready_o), 64'd1);
    step();
    req_valid_i = 1'b0;
    cnt = 1;
    while (!rsp_valid_o && cnt < 40) begin step(); cnt++; end
    check("t1_latency", 64'(cnt), 64'd6);
    check("t1_paddr", 64'(rsp_paddr_o), 64'h8000_1000);
    check("t1_ex", 64'(rsp_ex_valid_o), 64'd0);
    check("t1_timeout", 64'(rsp_timeout_o), 64'd0);
    step(); step();
    check("t1_mmu_reqs", 64'(n_mmu_req - base), 64'd1);
    check("t1_busy", 64'(busy_o), 64'd0);

    // 2: bypass, consumer stalled until the FIFO fills
    en_ld_st_translation_i = 1'b0; rsp_ready_i = 1'b0; base = n_mmu_req;
    for (int i = 0; i < 5; i++) begin
      va2[i] = 64'((i + 1) * 16);
      pa2[i] = va2[i];
    end
    va2[5] = 64'hFFFF_0000_0000_0060;
    pa2[5] = 64'h00FF_0000_0000_0060;
    for (int i = 0; i < 5; i++) begin
      req_valid_i = 1'b1; req_vaddr_i = va2[i];
      check($sformatf("t2_ready%0d", i), 64'(req_ready_o), 64'd1);
      step();
    end
    req_vaddr_i = va2[5];
    check("t2_full_bp", 64'(req_ready_o), 64'd0);
    check("t2_held_valid", 64'(rsp_valid_o), 64'd1);
    rsp_ready_i = 1'b1; acc = -1; k = 0;
    for (int i = 0; i < 40; i++) begin
      if (req_valid_i && req_ready_o && acc < 0) acc = i;
      if (rsp_valid_o && k < 6) begin
        check($sformatf("t2_rsp%0d", k), 64'(rsp_paddr_o), pa2[k]);
        k++;
      end
      step();
      if (acc >= 0) req_valid_i = 1'b0;
    end
    req_valid_i = 1'b0;
    check("t2_accept_cycle", 64'(acc), 64'd2);
    check("t2_rsp_count", 64'(k), 64'd6);
    check("t2_no_mmu_req", 64'(n_mmu_req - base), 64'd0);

    // 3: four stores, second one faults; rest discarded
    en_ld_st_translation_i = 1'b1; fault_va = 64'h3000_0020; base = n_mmu_req;
    for (int i = 0; i < 4; i++) begin
      req_valid_i = 1'b1; req_vaddr_i = 64'h3000_0010 + 64'(i * 16); req_is_store_i = 1'b1;
      check($sformatf("t3_ready%0d", i), 64'(req_ready_o), 64'd1);
      step();
    end
    req_valid_i = 1'b0; req_is_store_i = 1'b0;
    k = 0; cnt = 0;
    exp3_cause = STORE_PAGE_FAULT;
    while (k < 2 && cnt < 80) begin
      if (rsp_valid_o) begin
        if (k == 0) begin
          check("t3_rsp0_paddr", 64'(rsp_paddr_o), 64'h3000_0010);
          check("t3_rsp0_ex", 64'(rsp_ex_valid_o), 64'd0);
        end else begin
          check("t3_rsp1_ex", 64'(rsp_ex_valid_o), 64'd1);
          check("t3_rsp1_cause", rsp_ex_cause_o, exp3_cause);
          check("t3_rsp1_tval", rsp_ex_tval_o, 64'h3000_0020);
        end
        k++;
      end
      if (k < 2) begin step(); cnt++; end
    end
    check("t3_rsp_seen", 64'(k), 64'd2);
    step();
    check("t3_busy_drain", 64'(busy_o), 64'd1);
    step();
    check("t3_busy_idle", 64'(busy_o), 64'd0);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid_o) extra++;
      step();
    end
    check("t3_discarded", 64'(extra), 64'd0);
    check("t3_mmu_reqs", 64'(n_mmu_req - base), 64'd2);
    fault_va = '1;

    // 4: MMU answers too late -> timeout
    mmu_lat = 20;
    req_valid_i = 1'b1; req_vaddr_i = 64'h4000; step(); req_valid_i = 1'b0;
    cnt = 0;
    while (!mmu_req_o && cnt < 20) begin step(); cnt++; end
    check("t4_issue", 64'(mmu_req_o), 64'd1);
    step();
    cnt = 0;
    while (!rsp_valid_o && cnt < 60) begin step(); cnt++; end
    check("t4_timeout_cycles", 64'(cnt), 64'(TO));
    check("t4_timeout_flag", 64'(rsp_timeout_o), 64'd1);
    check("t4_paddr", 64'(rsp_paddr_o), 64'd0);
    check("t4_ex", 64'(rsp_ex_valid_o), 64'd0);
    step();
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid_o) extra++;
      step();
    end
    check("t4_late_ignored", 64'(extra), 64'd0);
    check("t4_busy", 64'(busy_o), 64'd0);
    mmu_lat = 3;

    // 5: flush during WAIT, stale answer must not surface
    ovr_va = 64'h1000; ovr_lat = 8; ovr_paddr = 56'hDEAD_0000;
    req_valid_i = 1'b1; req_vaddr_i = 64'h1000; step(); req_valid_i = 1'b0;
    cnt = 0;
    while (!mmu_req_o && cnt < 20) begin step(); cnt++; end
    step(); step(); step();
    flush_i = 1'b1; req_valid_i = 1'b1; req_vaddr_i = 64'h9999;
    #1;
    check("t5_flush_ready", 64'(req_ready_o), 64'd0);
    step();
    flush_i = 1'b0;
    check("t5_valid_after_flush", 64'(rsp_valid_o), 64'd0);
    check("t5_busy_discard", 64'(busy_o), 64'd1);
    req_vaddr_i = 64'h2000;
    step();
    req_valid_i = 1'b0;
    k = 0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid_o) begin
        check($sformatf("t5_rsp%0d_paddr", k), 64'(rsp_paddr_o), 64'h2000);
        k++;
      end
      step();
    end
    check("t5_rsp_count", 64'(k), 64'd1);
    ovr_va = '1;

    // 6: stalled response, reset mid-stall
    en_ld_st_translation_i = 1'b0; rsp_ready_i = 1'b0;
    req_valid_i = 1'b1; req_vaddr_i = 64'h6000; step(); req_valid_i = 1'b0;
    cnt = 0;
    while (!rsp_valid_o && cnt < 10) begin step(); cnt++; end
    req_valid_i = 1'b1; req_vaddr_i = 64'h7000;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t6_valid_c%0d", i), 64'(rsp_valid_o), 64'd1);
      check($sformatf("t6_paddr_c%0d", i), 64'(rsp_paddr_o), 64'h6000);
      step();
      req_valid_i = 1'b0;
    end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    check("t6_rst_valid", 64'(rsp_valid_o), 64'd0);
    check("t6_rst_paddr", 64'(rsp_paddr_o), 64'd0);
    check("t6_rst_ex", 64'(rsp_ex_valid_o), 64'd0);
    check("t6_rst_timeout", 64'(rsp_timeout_o), 64'd0);
    check("t6_rst_busy", 64'(busy_o), 64'd0);
    check("t6_rst_mmu_req", 64'(mmu_req_o), 64'd0);
    check("t6_rst_mmu_vaddr", mmu_vaddr_o, 64'd0);
    check("t6_rst_ready", 64'(req_ready_o), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
